// File: rtl/checker_pkg.sv
// Shared types and default viewport for the frame stream checker and its users.
// The 192x144 window matches the VGA_param.h display geometry.
package checker_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } checker_state_t;

    localparam int COORD_W       = 10;
    localparam int DEF_VIEW_LEFT = 0;
    localparam int DEF_VIEW_TOP  = 0;
    localparam int DEF_VIEW_W    = 192;
    localparam int DEF_VIEW_H    = 144;

    function automatic int view_pixels(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/pixel_channel_compare.sv
// Per-channel pixel compare: counts enabled channels whose value differs.
// Channel c occupies bits [c*CH_W +: CH_W], so the MSB channel is R.
module pixel_channel_compare #(
    parameter int NUM_CH = 3,
    parameter int CH_W   = 8,
    parameter int INC_W  = $clog2(NUM_CH + 1)
) (
    input  logic [NUM_CH*CH_W-1:0] got_i,
    input  logic [NUM_CH*CH_W-1:0] exp_i,
    input  logic [NUM_CH-1:0]      ch_en_i,
    output logic [INC_W-1:0]       inc_o
);

    always_comb begin
        inc_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_en_i[c] && (got_i[c*CH_W +: CH_W] != exp_i[c*CH_W +: CH_W]))
                inc_o = inc_o + INC_W'(1);
        end
    end

endmodule

// File: rtl/frame_stream_checker.sv
// Compares each in-window pixel of one displayed frame against an expected-pixel stream.
//   state   | meaning
//   S_IDLE  | after reset, nothing armed
//   S_WAIT  | armed, waiting for Frame_start
//   S_CHECK | consuming expected words for in-window pixels
//   S_DONE  | window finished or cut short by Frame_start
//   S_ABORT | mismatch limit exceeded
module frame_stream_checker
    import checker_pkg::*;
#(
    parameter int NUM_CH         = 3,
    parameter int CH_W           = 8,
    parameter int VIEW_LEFT      = DEF_VIEW_LEFT,
    parameter int VIEW_TOP       = DEF_VIEW_TOP,
    parameter int VIEW_W         = DEF_VIEW_W,
    parameter int VIEW_H         = DEF_VIEW_H,
    parameter int MAX_MISMATCHES = 10,
    parameter int CNT_W          = 20
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic                     Arm,
    input  logic                     Frame_start,
    input  logic [NUM_CH-1:0]        Channel_enable,
    input  logic                     Pixel_valid,
    input  logic [COORD_W-1:0]       Pixel_X,
    input  logic [COORD_W-1:0]       Pixel_Y,
    input  logic [NUM_CH*CH_W-1:0]   Pixel_data,
    input  logic                     Exp_valid,
    input  logic [NUM_CH*CH_W-1:0]   Exp_data,
    output logic                     Exp_ready,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Pass,
    output logic                     Limit_hit,
    output logic                     Underrun,
    output logic                     Incomplete,
    output logic [CNT_W-1:0]         Mismatch_count,
    output logic                     First_mm_valid,
    output logic [COORD_W-1:0]       First_mm_x,
    output logic [COORD_W-1:0]       First_mm_y,
    output logic [NUM_CH*CH_W-1:0]   First_mm_got,
    output logic [NUM_CH*CH_W-1:0]   First_mm_exp
);

    localparam int DW    = NUM_CH * CH_W;
    localparam int PIX_N = view_pixels(VIEW_W, VIEW_H);
    localparam int PW    = $clog2(PIX_N + 1);
    localparam int INC_W = $clog2(NUM_CH + 1);

    localparam logic [PW-1:0]      PIX_END  = PW'(PIX_N);
    localparam logic [PW-1:0]      PIX_LAST = PW'(PIX_N - 1);
    localparam logic [CNT_W-1:0]   MM_LIMIT = CNT_W'(MAX_MISMATCHES);
    localparam logic [COORD_W:0]   X_LO     = (COORD_W+1)'(VIEW_LEFT);
    localparam logic [COORD_W:0]   Y_LO     = (COORD_W+1)'(VIEW_TOP);
    localparam logic [COORD_W:0]   X_SPAN   = (COORD_W+1)'(VIEW_W);
    localparam logic [COORD_W:0]   Y_SPAN   = (COORD_W+1)'(VIEW_H);

    checker_state_t       state_q, state_d;
    logic [PW-1:0]        pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]     mm_cnt_q, mm_cnt_d;
    logic                 limit_q, limit_d;
    logic                 underrun_q, underrun_d;
    logic                 incomplete_q, incomplete_d;
    logic                 fmm_vld_q, fmm_vld_d;
    logic [COORD_W-1:0]   fmm_x_q, fmm_x_d;
    logic [COORD_W-1:0]   fmm_y_q, fmm_y_d;
    logic [DW-1:0]        fmm_got_q, fmm_got_d;
    logic [DW-1:0]        fmm_exp_q, fmm_exp_d;

    logic [COORD_W:0]     x_off, y_off;
    logic                 in_window, win_full, px_take, last_px;
    logic [INC_W-1:0]     inc;
    logic [CNT_W:0]       cnt_sum;
    logic [CNT_W-1:0]     cnt_sat;
    logic                 hit, abort_now;

    pixel_channel_compare #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .INC_W  (INC_W)
    ) u_cmp (
        .got_i   (Pixel_data),
        .exp_i   (Exp_data),
        .ch_en_i (Channel_enable),
        .inc_o   (inc)
    );

    // Offsets wrap to large values left/above the window, so one unsigned compare covers both bounds.
    assign x_off     = {1'b0, Pixel_X} - X_LO;
    assign y_off     = {1'b0, Pixel_Y} - Y_LO;
    assign in_window = (x_off < X_SPAN) && (y_off < Y_SPAN);
    assign win_full  = (pix_cnt_q == PIX_END);
    assign px_take   = (state_q == S_CHECK) && Pixel_valid && in_window && !win_full;
    assign last_px   = px_take && (pix_cnt_q == PIX_LAST);
    assign Exp_ready = px_take && Exp_valid;

    assign cnt_sum   = {1'b0, mm_cnt_q} + (CNT_W+1)'(inc);
    assign cnt_sat   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    assign hit       = Exp_ready && (inc != '0);
    assign abort_now = hit && (MAX_MISMATCHES != 0) && (cnt_sat > MM_LIMIT);

    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        mm_cnt_d     = mm_cnt_q;
        limit_d      = limit_q;
        underrun_d   = underrun_q;
        incomplete_d = incomplete_q;
        fmm_vld_d    = fmm_vld_q;
        fmm_x_d      = fmm_x_q;
        fmm_y_d      = fmm_y_q;
        fmm_got_d    = fmm_got_q;
        fmm_exp_d    = fmm_exp_q;

        case (state_q)
            S_IDLE, S_DONE, S_ABORT: begin
                if (Arm) begin
                    state_d      = S_WAIT;
                    pix_cnt_d    = '0;
                    mm_cnt_d     = '0;
                    limit_d      = 1'b0;
                    underrun_d   = 1'b0;
                    incomplete_d = 1'b0;
                    fmm_vld_d    = 1'b0;
                    fmm_x_d      = '0;
                    fmm_y_d      = '0;
                    fmm_got_d    = '0;
                    fmm_exp_d    = '0;
                end
            end
            S_WAIT: begin
                if (Frame_start)
                    state_d = S_CHECK;
            end
            S_CHECK: begin
                if (px_take) begin
                    pix_cnt_d = pix_cnt_q + PW'(1);
                    if (!Exp_valid)
                        underrun_d = 1'b1;
                end
                if (hit) begin
                    mm_cnt_d = cnt_sat;
                    if (!fmm_vld_q) begin
                        fmm_vld_d = 1'b1;
                        fmm_x_d   = Pixel_X;
                        fmm_y_d   = Pixel_Y;
                        fmm_got_d = Pixel_data;
                        fmm_exp_d = Exp_data;
                    end
                end
                // A Frame_start landing on the last window pixel still counts as a complete frame.
                if (abort_now) begin
                    limit_d = 1'b1;
                    state_d = S_ABORT;
                end else if (win_full) begin
                    state_d = S_DONE;
                end else if (Frame_start && !last_px) begin
                    incomplete_d = 1'b1;
                    state_d      = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q      <= S_IDLE;
            pix_cnt_q    <= '0;
            mm_cnt_q     <= '0;
            limit_q      <= 1'b0;
            underrun_q   <= 1'b0;
            incomplete_q <= 1'b0;
            fmm_vld_q    <= 1'b0;
            fmm_x_q      <= '0;
            fmm_y_q      <= '0;
            fmm_got_q    <= '0;
            fmm_exp_q    <= '0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            mm_cnt_q     <= mm_cnt_d;
            limit_q      <= limit_d;
            underrun_q   <= underrun_d;
            incomplete_q <= incomplete_d;
            fmm_vld_q    <= fmm_vld_d;
            fmm_x_q      <= fmm_x_d;
            fmm_y_q      <= fmm_y_d;
            fmm_got_q    <= fmm_got_d;
            fmm_exp_q    <= fmm_exp_d;
        end
    end

    assign Busy           = (state_q == S_WAIT) || (state_q == S_CHECK);
    assign Done           = (state_q == S_DONE) || (state_q == S_ABORT);
    assign Pass           = (state_q == S_DONE) && (mm_cnt_q == '0) && !underrun_q && !incomplete_q;
    assign Limit_hit      = limit_q;
    assign Underrun       = underrun_q;
    assign Incomplete     = incomplete_q;
    assign Mismatch_count = mm_cnt_q;
    assign First_mm_valid = fmm_vld_q;
    assign First_mm_x     = fmm_x_q;
    assign First_mm_y     = fmm_y_q;
    assign First_mm_got   = fmm_got_q;
    assign First_mm_exp   = fmm_exp_q;

endmodule

// File: tb/tb_frame_stream_checker.sv
// Directed bench for frame_stream_checker at the default 192x144 viewport.
module tb_frame_stream_checker;

    localparam int W = 192;
    localparam int H = 144;
    localparam int N = W * H;

    logic        Clock, Resetn, Arm, Frame_start;
    logic [2:0]  Channel_enable;
    logic        Pixel_valid;
    logic [9:0]  Pixel_X, Pixel_Y;
    logic [23:0] Pixel_data, Exp_data;
    logic        Exp_valid, Exp_ready;
    logic        Busy, Done, Pass, Limit_hit, Underrun, Incomplete;
    logic [19:0] Mismatch_count;
    logic        First_mm_valid;
    logic [9:0]  First_mm_x, First_mm_y;
    logic [23:0] First_mm_got, First_mm_exp;

    int checks = 0;
    int failures = 0;
    int ready_cnt = 0;

    frame_stream_checker dut (
        .Clock(Clock), .Resetn(Resetn), .Arm(Arm), .Frame_start(Frame_start),
        .Channel_enable(Channel_enable), .Pixel_valid(Pixel_valid),
        .Pixel_X(Pixel_X), .Pixel_Y(Pixel_Y), .Pixel_data(Pixel_data),
        .Exp_valid(Exp_valid), .Exp_data(Exp_data), .Exp_ready(Exp_ready),
        .Busy(Busy), .Done(Done), .Pass(Pass), .Limit_hit(Limit_hit),
        .Underrun(Underrun), .Incomplete(Incomplete), .Mismatch_count(Mismatch_count),
        .First_mm_valid(First_mm_valid), .First_mm_x(First_mm_x), .First_mm_y(First_mm_y),
        .First_mm_got(First_mm_got), .First_mm_exp(First_mm_exp)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [23:0] pix(input int k);
        logic [31:0] u;
        u = k;
        return {u[7:0], u[15:8], u[7:0] ^ 8'h5A};
    endfunction

    // Drive one cycle of inputs at the falling edge; Exp_ready is sampled 1 ns later.
    task automatic step(input logic pv, input int x, input int y, input logic [23:0] pd,
                        input logic ev, input logic [23:0] ed, input logic fs, input logic [2:0] ce);
        @(negedge Clock);
        Arm = 1'b0;
        Pixel_valid = pv; Pixel_X = 10'(x); Pixel_Y = 10'(y); Pixel_data = pd;
        Exp_valid = ev; Exp_data = ed; Frame_start = fs; Channel_enable = ce;
        #1;
        if (Exp_ready === 1'b1) ready_cnt++;
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 24'h0, 1'b0, 24'h0, 1'b0, 3'b111);
    endtask

    task automatic do_arm();
        @(negedge Clock);
        Arm = 1'b1; Pixel_valid = 1'b0; Exp_valid = 1'b0; Frame_start = 1'b0;
        @(negedge Clock);
        Arm = 1'b0;
        #1;
        ready_cnt = 0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (Done !== 1'b1 && n < 10) begin
            idle();
            n++;
        end
        checks++;
        if (Done !== 1'b1) begin failures++; $display("FAIL %s_done_timeout: Done=%0b want 1", name, Done); end
    endtask

    task automatic test_reset();
        Resetn = 1'b0; Arm = 1'b0; Frame_start = 1'b0; Channel_enable = 3'b111;
        Pixel_valid = 1'b1; Pixel_X = 10'd0; Pixel_Y = 10'd0; Pixel_data = 24'h1;
        Exp_valid = 1'b1; Exp_data = 24'h2;
        repeat (3) @(negedge Clock);
        #1;
        checks++;
        if ({Busy, Done, Pass, Limit_hit, Underrun, Incomplete, First_mm_valid, Exp_ready,
             Mismatch_count, First_mm_x, First_mm_y, First_mm_got, First_mm_exp} !== 96'h0) begin
            failures++;
            $display("FAIL reset_outputs: some output nonzero busy=%0b done=%0b cnt=%0h rdy=%0b",
                     Busy, Done, Mismatch_count, Exp_ready);
        end
        Resetn = 1'b1;
        step(1'b0, 0, 0, 24'h0, 1'b0, 24'h0, 1'b1, 3'b111);
        step(1'b1, 0, 0, 24'h1, 1'b1, 24'h2, 1'b0, 3'b111);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            failures++; $display("FAIL idle_frame_start: busy=%0b done=%0b want 0 0", Busy, Done);
        end
        checks++;
        if (Exp_ready !== 1'b0) begin failures++; $display("FAIL idle_exp_ready: got %0b want 0", Exp_ready); end
    endtask

    // Identical stream; second half masks R and corrupts it; Frame_start on the last pixel.
    task automatic test_identical_frame();
        logic [23:0] d, e;
        logic [2:0]  ce;
        do_arm();
        checks++;
        if (Busy !== 1'b1 || Done !== 1'b0) begin
            failures++; $display("FAIL arm_busy: busy=%0b done=%0b want 1 0", Busy, Done);
        end
        step(1'b0, 0, 0, 24'h0, 1'b0, 24'h0, 1'b1, 3'b111);
        step(1'b1, 200, 0, 24'h111111, 1'b1, 24'h222222, 1'b0, 3'b111);
        step(1'b1, 0, 150, 24'h111111, 1'b1, 24'h222222, 1'b0, 3'b111);
        step(1'b1, 192, 143, 24'h111111, 1'b1, 24'h222222, 1'b0, 3'b111);
        step(1'b0, 5, 5, 24'h111111, 1'b1, 24'h222222, 1'b0, 3'b111);
        idle();
        checks++;
        if (ready_cnt !== 0) begin failures++; $display("FAIL oow_ready: consumed %0d want 0", ready_cnt); end
        checks++;
        if (Mismatch_count !== 20'd0) begin failures++; $display("FAIL oow_count: got %0d want 0", Mismatch_count); end
        for (int k = 0; k < N; k++) begin
            d = pix(k);
            e = d;
            ce = 3'b111;
            if (k >= N / 2) begin
                ce = 3'b011;
                e[23:16] = ~d[23:16];
            end
            step(1'b1, k % W, k / W, d, 1'b1, e, (k == N - 1), ce);
        end
        wait_done("ident");
        checks++;
        if (Pass !== 1'b1) begin failures++; $display("FAIL ident_pass: got %0b want 1", Pass); end
        checks++;
        if (Mismatch_count !== 20'd0) begin failures++; $display("FAIL ident_count: got %0d want 0", Mismatch_count); end
        checks++;
        if (ready_cnt !== N) begin failures++; $display("FAIL ident_consumed: got %0d want %0d", ready_cnt, N); end
        checks++;
        if (Incomplete !== 1'b0 || First_mm_valid !== 1'b0) begin
            failures++; $display("FAIL ident_flags: incomplete=%0b fmm_valid=%0b want 0 0", Incomplete, First_mm_valid);
        end
        step(1'b0, 0, 0, 24'h0, 1'b0, 24'h0, 1'b1, 3'b111);
        idle();
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0 || Pass !== 1'b1) begin
            failures++; $display("FAIL done_frame_start: done=%0b busy=%0b pass=%0b want 1 0 1", Done, Busy, Pass);
        end
    endtask

    // Underrun at pixel 100, all-channel mismatch at (5,7), ignored Arm mid-frame.
    task automatic test_mismatch_underrun();
        logic [23:0] d, e;
        logic        ev;
        do_arm();
        step(1'b0, 0, 0, 24'h0, 1'b0, 24'h0, 1'b1, 3'b111);
        for (int k = 0; k < N; k++) begin
            d = pix(k);
            e = d;
            ev = (k != 100);
            if (k == 7 * W + 5) begin
                d = {8'h12, d[15:0]};
                e = {8'h13, d[15:8] ^ 8'h01, d[7:0] ^ 8'h80};
            end
            step(1'b1, k % W, k / W, d, ev, e, 1'b0, 3'b111);
            if (k == 100) begin
                checks++;
                if (Exp_ready !== 1'b0) begin failures++; $display("FAIL underrun_ready: got %0b want 0", Exp_ready); end
            end
            if (k == 101) begin
                checks++;
                if (Underrun !== 1'b1 || Mismatch_count !== 20'd0) begin
                    failures++; $display("FAIL underrun_flag: underrun=%0b cnt=%0d want 1 0", Underrun, Mismatch_count);
                end
            end
            if (k == 7 * W + 5) begin
                checks++;
                if (Mismatch_count !== 20'd0) begin failures++; $display("FAIL mm_latency: got %0d want 0", Mismatch_count); end
            end
            if (k == 7 * W + 6) begin
                checks++;
                if (Mismatch_count !== 20'd3) begin failures++; $display("FAIL mm_count: got %0d want 3", Mismatch_count); end
                checks++;
                if (First_mm_valid !== 1'b1 || First_mm_x !== 10'd5 || First_mm_y !== 10'd7) begin
                    failures++; $display("FAIL mm_coord: valid=%0b x=%0d y=%0d want 1 5 7", First_mm_valid, First_mm_x, First_mm_y);
                end
                checks++;
                if (First_mm_got !== 24'h12051F || First_mm_exp !== 24'h13049F) begin
                    failures++; $display("FAIL mm_data: got=%h exp=%h want 12051f 13049f", First_mm_got, First_mm_exp);
                end
            end
            if (k == 2000) Arm = 1'b1;
            if (k == 2001) begin
                checks++;
                if (Busy !== 1'b1 || Underrun !== 1'b1 || Mismatch_count !== 20'd3) begin
                    failures++; $display("FAIL arm_in_check: busy=%0b underrun=%0b cnt=%0d want 1 1 3", Busy, Underrun, Mismatch_count);
                end
            end
        end
        wait_done("mmur");
        checks++;
        if (Pass !== 1'b0 || Underrun !== 1'b1 || Incomplete !== 1'b0) begin
            failures++; $display("FAIL mmur_flags: pass=%0b underrun=%0b incomplete=%0b want 0 1 0", Pass, Underrun, Incomplete);
        end
        checks++;
        if (Mismatch_count !== 20'd3) begin failures++; $display("FAIL mmur_count: got %0d want 3", Mismatch_count); end
        checks++;
        if (ready_cnt !== N - 1) begin failures++; $display("FAIL mmur_consumed: got %0d want %0d", ready_cnt, N - 1); end
    endtask

    task automatic test_abort();
        logic [23:0] d;
        int exp_cnt [6] = '{0, 3, 6, 9, 12, 12};
        do_arm();
        checks++;
        if (Underrun !== 1'b0 || Mismatch_count !== 20'd0 || First_mm_valid !== 1'b0) begin
            failures++; $display("FAIL arm_clear: underrun=%0b cnt=%0d fmm=%0b want 0 0 0", Underrun, Mismatch_count, First_mm_valid);
        end
        step(1'b0, 0, 0, 24'h0, 1'b0, 24'h0, 1'b1, 3'b111);
        for (int k = 0; k < 6; k++) begin
            d = pix(k);
            step(1'b1, k, 0, d, 1'b1, ~d, 1'b0, 3'b111);
            checks++;
            if (Mismatch_count !== 20'(exp_cnt[k])) begin
                failures++; $display("FAIL abort_count_%0d: got %0d want %0d", k, Mismatch_count, exp_cnt[k]);
            end
            checks++;
            if (Limit_hit !== (k >= 4)) begin
                failures++; $display("FAIL abort_limit_%0d: got %0b want %0b", k, Limit_hit, (k >= 4));
            end
        end
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0 || Pass !== 1'b0) begin
            failures++; $display("FAIL abort_state: done=%0b busy=%0b pass=%0b want 1 0 0", Done, Busy, Pass);
        end
        checks++;
        if (ready_cnt !== 4) begin failures++; $display("FAIL abort_consumed: got %0d want 4", ready_cnt); end
    endtask

    task automatic test_incomplete();
        do_arm();
        step(1'b0, 0, 0, 24'h0, 1'b0, 24'h0, 1'b1, 3'b111);
        for (int k = 0; k < 5000; k++)
            step(1'b1, k % W, k / W, pix(k), 1'b1, pix(k), 1'b0, 3'b111);
        step(1'b0, 0, 0, 24'h0, 1'b0, 24'h0, 1'b1, 3'b111);
        idle();
        checks++;
        if (Incomplete !== 1'b1 || Done !== 1'b1 || Pass !== 1'b0) begin
            failures++; $display("FAIL incomplete_flags: incomplete=%0b done=%0b pass=%0b want 1 1 0", Incomplete, Done, Pass);
        end
        checks++;
        if (ready_cnt !== 5000) begin failures++; $display("FAIL incomplete_consumed: got %0d want 5000", ready_cnt); end
    endtask

    task automatic test_reset_midframe();
        logic [23:0] d;
        do_arm();
        step(1'b0, 0, 0, 24'h0, 1'b0, 24'h0, 1'b1, 3'b111);
        for (int k = 0; k < 50; k++) begin
            d = pix(k);
            step(1'b1, k, 0, d, 1'b1, (k == 3) ? ~d : d, 1'b0, 3'b111);
        end
        checks++;
        if (Mismatch_count !== 20'd3 || Busy !== 1'b1) begin
            failures++; $display("FAIL midreset_pre: cnt=%0d busy=%0b want 3 1", Mismatch_count, Busy);
        end
        @(negedge Clock);
        Resetn = 1'b0; Pixel_valid = 1'b1; Pixel_X = 10'd60; Pixel_Y = 10'd0; Exp_valid = 1'b1;
        @(negedge Clock);
        #1;
        checks++;
        if ({Busy, Done, Pass, Limit_hit, Underrun, Incomplete, First_mm_valid, Exp_ready,
             Mismatch_count, First_mm_x, First_mm_y, First_mm_got, First_mm_exp} !== 96'h0) begin
            failures++;
            $display("FAIL midreset_outputs: some output nonzero busy=%0b cnt=%0d fmm=%0b rdy=%0b",
                     Busy, Mismatch_count, First_mm_valid, Exp_ready);
        end
        Resetn = 1'b1;
        idle();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            failures++; $display("FAIL midreset_idle: busy=%0b done=%0b want 0 0", Busy, Done);
        end
    endtask

    initial begin
        test_reset();
        test_identical_frame();
        test_mismatch_underrun();
        test_abort();
        test_incomplete();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
